// File: rtl/sts_capture_ctrl.sv
// -----------------------------------------------------------------------------
// sts_capture_ctrl
//
// Captures an 8-bit status vector for a CPU read. Each bit is either sticky
// (latched on a rising edge, cleared when it has been reported by a read) or
// transparent (sampled live when the read snapshot is taken). A level
// interrupt reports enabled sticky bits. An optional saturating counter
// records sticky events that hit a bit which was already set.
//
// Parameters:
//   ModeMask  per-bit mode: 1 = sticky, 0 = transparent
//   IntMask   per-bit interrupt enable; only sticky bits can interrupt
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   status_in  in   [7:0] raw event/status nets
//   rd_req     in   CPU read request
//   rd_ack     out  read data valid
//   rd_data    out  [7:0] status snapshot
//   irq        out  registered level interrupt
//   ovf_count  out  [7:0] saturating count of lost sticky events
//   state_o    out  [1:0] FSM state (IDLE=0, SNAP=1, HOLD=2, CLEAR=3)
//
// Read handshake (four-phase): the CPU raises rd_req and keeps it high until
// it sees rd_ack; rd_data is valid and frozen while rd_ack is high; the CPU
// then drops rd_req, rd_ack falls on the next edge, and the sticky bits that
// were reported are cleared one cycle later. A request that drops before
// rd_ack still gets a one-cycle rd_ack pulse.
//
// Configuration macro: STS_CAPTURE_CTRL_OVF_CNT_EN enables the overflow
// counter; without it ovf_count is tied to 8'h00.
// -----------------------------------------------------------------------------
module sts_capture_ctrl #(
  parameter logic [7:0] ModeMask = 8'h00,
  parameter logic [7:0] IntMask  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] status_in,
  input  logic       rd_req,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       irq,
  output logic [7:0] ovf_count,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  state_e     state_q;
  logic [7:0] status_dly_q;  // previous-cycle status_in, for edge detect
  logic [7:0] sticky_q;
  logic [7:0] sticky_d;
  logic [7:0] rise;
  logic [7:0] snap_data;

  assign state_o = state_q;

  always_comb begin
    rise = status_in & ~status_dly_q;
    // Snapshot includes sticky events rising in the SNAP cycle itself, so
    // they are reported now and cleared by the following CLEAR.
    snap_data = ((sticky_q | (rise & ModeMask)) & ModeMask) |
                (status_in & ~ModeMask);
    if (state_q == CLEAR) begin
      // Only bits that were reported are cleared; new rises survive.
      sticky_d = (sticky_q & ~rd_data & ModeMask) | (rise & ModeMask);
    end else begin
      sticky_d = sticky_q | (rise & ModeMask);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      status_dly_q <= 8'h00;
      sticky_q     <= 8'h00;
      rd_data      <= 8'h00;
      rd_ack       <= 1'b0;
      irq          <= 1'b0;
    end else begin
      status_dly_q <= status_in;
      sticky_q     <= sticky_d;
      irq          <= |(sticky_d & IntMask & ModeMask);
      case (state_q)
        IDLE: begin
          if (rd_req) state_q <= SNAP;
        end
        SNAP: begin
          rd_data <= snap_data;
          rd_ack  <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (!rd_req) begin
            rd_ack  <= 1'b0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STS_CAPTURE_CTRL_OVF_CNT_EN
  // A rise on a sticky bit that is already set cannot be recorded in the
  // status byte; count at most one such loss per cycle.
  logic       ovf_hit;
  logic [7:0] ovf_q;

  assign ovf_hit   = |(rise & ModeMask & sticky_q);
  assign ovf_count = ovf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 8'h00;
    end else if (state_q == CLEAR) begin
      ovf_q <= {7'd0, ovf_hit};
    end else if (ovf_hit && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end
`else
  assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_sts_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sts_capture_ctrl
//
// Directed bench for sts_capture_ctrl. u_dut uses ModeMask=8'h0F,
// IntMask=8'h01 (sticky low nibble, irq on bit 0); u_dut_t is all
// transparent. Inputs are driven and outputs sampled 1 ns after the rising
// edge. Read data expectations go through exp_q.
// -----------------------------------------------------------------------------
module tb_sts_capture_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [7:0] status_a = 8'h00;
  logic       rd_req_a = 1'b0;
  logic       rd_ack_a;
  logic [7:0] rd_data_a;
  logic       irq_a;
  logic [7:0] ovf_a;
  logic [1:0] state_a;

  logic [7:0] status_b = 8'h00;
  logic       rd_req_b = 1'b0;
  logic       rd_ack_b;
  logic [7:0] rd_data_b;
  logic       irq_b;
  logic [7:0] ovf_b;
  logic [1:0] state_b;

  sts_capture_ctrl #(.ModeMask(8'h0F), .IntMask(8'h01)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .status_in (status_a),
    .rd_req    (rd_req_a),
    .rd_ack    (rd_ack_a),
    .rd_data   (rd_data_a),
    .irq       (irq_a),
    .ovf_count (ovf_a),
    .state_o   (state_a)
  );

  sts_capture_ctrl #(.ModeMask(8'h00), .IntMask(8'h00)) u_dut_t (
    .clock     (clock),
    .reset     (reset),
    .status_in (status_b),
    .rd_req    (rd_req_b),
    .rd_ack    (rd_ack_b),
    .rd_data   (rd_data_b),
    .irq       (irq_b),
    .ovf_count (ovf_b),
    .state_o   (state_b)
  );

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SNAP  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

`ifdef STS_CAPTURE_CTRL_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] bits);
    status_a = bits;
    tick();
    status_a = 8'h00;
    tick();
  endtask

  // Full read on u_dut with rd_req held for one extra HOLD cycle.
  task automatic read_a(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    rd_req_a = 1'b1;
    tick();
    check({tag, " state SNAP"}, state_a, S_SNAP);
    check({tag, " ack low in SNAP"}, rd_ack_a, 1'b0);
    tick();
    check({tag, " ack"}, rd_ack_a, 1'b1);
    e = exp_q.pop_front();
    check({tag, " rd_data"}, rd_data_a, e);
    tick();
    check({tag, " rd_data frozen"}, rd_data_a, e);
    rd_req_a = 1'b0;
    tick();
    check({tag, " state CLEAR"}, state_a, S_CLEAR);
    check({tag, " ack drop"}, rd_ack_a, 1'b0);
    tick();
    check({tag, " state IDLE"}, state_a, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    tick();
    // Reset values
    check("rst state", state_a, S_IDLE);
    check("rst rd_ack", rd_ack_a, 1'b0);
    check("rst rd_data", rd_data_a, 8'h00);
    check("rst irq", irq_a, 1'b0);
    check("rst ovf", ovf_a, 8'h00);
    reset = 1'b0;
    tick();

    // Sticky capture with interrupt on bit 0
    status_a = 8'h01;
    tick();
    status_a = 8'h00;
    tick();
    check("sticky irq set", irq_a, 1'b1);
    read_a("sticky read", 8'h01);
    check("sticky irq cleared", irq_a, 1'b0);
    read_a("sticky reread", 8'h00);

    // Transparent bits are sampled live and never stored
    status_a = 8'h30;
    tick();
    read_a("transp live", 8'h30);
    status_a = 8'h00;
    tick();
    read_a("transp not stored", 8'h00);

    // Rise during SNAP cycle is captured and then cleared
    rd_req_a = 1'b1;
    tick();
    status_a = 8'h08;
    tick();
    status_a = 8'h00;
    check("snap rise ack", rd_ack_a, 1'b1);
    check("snap rise data", rd_data_a, 8'h08);
    rd_req_a = 1'b0;
    tick();
    tick();
    read_a("snap rise cleared", 8'h00);

    // Event during HOLD is not in the current snapshot but survives CLEAR
    rd_req_a = 1'b1;
    tick();
    tick();
    check("hold ev ack", rd_ack_a, 1'b1);
    status_a = 8'h02;
    tick();
    status_a = 8'h00;
    check("hold ev data frozen", rd_data_a, 8'h00);
    check("hold ev state", state_a, S_HOLD);
    rd_req_a = 1'b0;
    tick();
    tick();
    check("hold ev irq masked", irq_a, 1'b0);
    read_a("hold ev next read", 8'h02);

    // Short request: one-cycle rd_ack pulse
    rd_req_a = 1'b1;
    tick();
    rd_req_a = 1'b0;
    tick();
    check("short ack high", rd_ack_a, 1'b1);
    check("short state HOLD", state_a, S_HOLD);
    tick();
    check("short ack low", rd_ack_a, 1'b0);
    check("short state CLEAR", state_a, S_CLEAR);
    tick();
    check("short state IDLE", state_a, S_IDLE);

    // Overflow: repeated rises on sticky bit 2
    for (int i = 0; i < 10; i++) pulse_a(8'h04);
    check("ovf after 10", ovf_a, OVF_EN ? 8'd9 : 8'd0);
    for (int i = 0; i < 290; i++) pulse_a(8'h04);
    check("ovf saturate", ovf_a, OVF_EN ? 8'hFF : 8'h00);
    read_a("ovf read", 8'h04);
    check("ovf cleared", ovf_a, 8'h00);

    // Overflow and rise in the CLEAR cycle itself
    pulse_a(8'h04);
    rd_req_a = 1'b1;
    tick();
    tick();
    check("clr ovf data", rd_data_a, 8'h04);
    rd_req_a = 1'b0;
    tick();
    check("clr ovf in CLEAR", state_a, S_CLEAR);
    status_a = 8'h04;
    tick();
    status_a = 8'h00;
    check("clr ovf count", ovf_a, OVF_EN ? 8'd1 : 8'd0);
    tick();
    read_a("clr ovf kept", 8'h04);
    check("clr ovf reset by read", ovf_a, 8'h00);

    // Reset while in HOLD
    pulse_a(8'h01);
    check("rh irq before", irq_a, 1'b1);
    rd_req_a = 1'b1;
    tick();
    tick();
    check("rh ack before", rd_ack_a, 1'b1);
    reset = 1'b1;
    rd_req_a = 1'b0;
    status_a = 8'h01;
    tick();
    check("rh ack", rd_ack_a, 1'b0);
    check("rh rd_data", rd_data_a, 8'h00);
    check("rh irq", irq_a, 1'b0);
    check("rh state", state_a, S_IDLE);
    tick();
    // status held high across reset release counts as a rise
    reset = 1'b0;
    tick();
    check("rel rise irq", irq_a, 1'b1);
    status_a = 8'h00;
    read_a("rel rise read", 8'h01);

    // Transparent-only instance
    status_b = 8'hA5;
    tick();
    rd_req_b = 1'b1;
    tick();
    check("tb ack in SNAP", rd_ack_b, 1'b0);
    tick();
    check("tb ack", rd_ack_b, 1'b1);
    check("tb rd_data", rd_data_b, 8'hA5);
    check("tb irq", irq_b, 1'b0);
    rd_req_b = 1'b0;
    tick();
    tick();
    check("tb state IDLE", state_b, S_IDLE);
    status_b = 8'h5A;
    tick();
    rd_req_b = 1'b1;
    tick();
    tick();
    check("tb rd_data live", rd_data_b, 8'h5A);
    rd_req_b = 1'b0;
    tick();
    tick();
    check("tb irq end", irq_b, 1'b0);
    check("tb ovf", ovf_b, 8'h00);

    check("exp_q drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
